// File: rtl/ram_pkg.sv
// Shared read-during-write encodings and the lane-masked merge helper for ram_dual_port.
// The merge works on the widest supported word; callers size-cast in and out.
package ram_pkg;

  localparam int RAM_READ_FIRST  = 0;
  localparam int RAM_WRITE_FIRST = 1;
  localparam int RAM_NO_CHANGE   = 2;

  localparam int RAM_MAX_WIDTH = 1024;

  typedef logic [RAM_MAX_WIDTH-1:0] ram_word_t;

  function automatic ram_word_t ram_merge(input ram_word_t old_w,
                                          input ram_word_t new_w,
                                          input ram_word_t lane_mask);
    return (old_w & ~lane_mask) | (new_w & lane_mask);
  endfunction

endpackage

// File: rtl/ram_port_pipe.sv
// Read-return register for one RAM port plus an optional extra output stage.
// Latency 1+OUT_REG; data holds between valid beats; no backpressure.
module ram_port_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  req_vld,
  input  logic [DATA_WIDTH-1:0] req_dat,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_dat
);

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_dat;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= req_vld;
      if (req_vld) s1_dat <= req_dat;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_vld;
    logic [DATA_WIDTH-1:0] s2_dat;

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        s2_vld <= 1'b0;
        s2_dat <= '0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) s2_dat <= s1_dat;
      end
    end

    assign out_vld = s2_vld;
    assign out_dat = s2_dat;
  end else begin : g_no_out_reg
    assign out_vld = s1_vld;
    assign out_dat = s1_dat;
  end

endmodule

// File: rtl/ram_dual_port.sv
// True dual-port RAM with per-lane write enables and selectable read-during-write mode.
// Read latency 1+OUT_REG; no backpressure, each port accepts one access every cycle.
module ram_dual_port
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int RW_MODE    = 0,
  parameter int OUT_REG    = 1
) (
  input  logic                             Clk,
  input  logic                             Rst_n,
  input  logic                             EnA,
  input  logic                             WriteA,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] ByteEnA,
  input  logic [ADDR_WIDTH-1:0]            AddrA,
  input  logic [DATA_WIDTH-1:0]            InputA,
  output logic [DATA_WIDTH-1:0]            OutputA,
  output logic                             ValidA,
  input  logic                             EnB,
  input  logic                             WriteB,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] ByteEnB,
  input  logic [ADDR_WIDTH-1:0]            AddrB,
  input  logic [DATA_WIDTH-1:0]            InputB,
  output logic [DATA_WIDTH-1:0]            OutputB,
  output logic                             ValidB,
  output logic                             Collision
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || RW_MODE < 0 || RW_MODE > 2 ||
      DATA_WIDTH > RAM_MAX_WIDTH) begin : g_param_check
    $error("ram_dual_port: illegal DATA_WIDTH/BYTE_WIDTH/RW_MODE combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_a, wr_b, ww_same;
  logic                  rd_vld_a, rd_vld_b;
  logic [DATA_WIDTH-1:0] mask_a, mask_b;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, post_b;
  logic [DATA_WIDTH-1:0] rd_dat_a, rd_dat_b;

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                  input logic [DATA_WIDTH-1:0] new_w,
                                                  input logic [DATA_WIDTH-1:0] lane_mask);
    return DATA_WIDTH'(ram_merge(RAM_MAX_WIDTH'(old_w), RAM_MAX_WIDTH'(new_w),
                                 RAM_MAX_WIDTH'(lane_mask)));
  endfunction

  assign wr_a    = EnA && WriteA;
  assign wr_b    = EnB && WriteB;
  assign ww_same = wr_a && wr_b && (AddrA == AddrB);
  assign old_a   = mem[AddrA];
  assign old_b   = mem[AddrB];

  always_comb begin
    mask_a = '0;
    mask_b = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      mask_a[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{ByteEnA[i]}};
      mask_b[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{ByteEnB[i]}};
    end
  end

  // On a write/write collision B's lanes are folded in first so A's lanes land on top.
  assign new_a  = merge(ww_same ? merge(old_a, InputB, mask_b) : old_a, InputA, mask_a);
  assign new_b  = merge(old_b, InputB, mask_b);
  assign post_b = ww_same ? new_a : new_b;

  always_ff @(posedge Clk) begin
    if (wr_a) mem[AddrA] <= new_a;
    if (wr_b && !ww_same) mem[AddrB] <= new_b;
  end

  // A reading port always sees the pre-write word; only a port's own write can select post-write.
  always_comb begin
    rd_dat_a = old_a;
    rd_dat_b = old_b;
    if (wr_a && RW_MODE == RAM_WRITE_FIRST) rd_dat_a = new_a;
    if (wr_b && RW_MODE == RAM_WRITE_FIRST) rd_dat_b = post_b;
  end

  assign rd_vld_a = EnA && !(WriteA && (RW_MODE == RAM_NO_CHANGE));
  assign rd_vld_b = EnB && !(WriteB && (RW_MODE == RAM_NO_CHANGE));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Collision <= 1'b0;
    end else begin
      Collision <= EnA && EnB && (AddrA == AddrB) && (WriteA || WriteB);
    end
  end

  ram_port_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_pipe_a (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .req_vld (rd_vld_a),
    .req_dat (rd_dat_a),
    .out_vld (ValidA),
    .out_dat (OutputA)
  );

  ram_port_pipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_pipe_b (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .req_vld (rd_vld_b),
    .req_dat (rd_dat_b),
    .out_vld (ValidB),
    .out_dat (OutputB)
  );

endmodule

// File: tb/tb_ram_dual_port.sv
// Six RAM instances (all RW_MODE x OUT_REG combinations) share one directed stimulus
// stream and are checked every cycle against a word-level memory model.
module tb_ram_dual_port;

  localparam int NC = 6;  // c<3: OUT_REG=1, c>=3: OUT_REG=0; RW_MODE = c%3

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a, wr_a, en_b, wr_b;
  logic [3:0]  be_a, be_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] in_a, in_b;

  logic [31:0] out_a [NC];
  logic [31:0] out_b [NC];
  logic        vld_a [NC];
  logic        vld_b [NC];
  logic        coll  [NC];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    ram_dual_port #(
      .DATA_WIDTH(32), .ADDR_WIDTH(8), .BYTE_WIDTH(8),
      .RW_MODE(g % 3), .OUT_REG(g < 3 ? 1 : 0)
    ) u_dut (
      .Clk(clk), .Rst_n(rst_n),
      .EnA(en_a), .WriteA(wr_a), .ByteEnA(be_a), .AddrA(addr_a), .InputA(in_a),
      .OutputA(out_a[g]), .ValidA(vld_a[g]),
      .EnB(en_b), .WriteB(wr_b), .ByteEnB(be_b), .AddrB(addr_b), .InputB(in_b),
      .OutputB(out_b[g]), .ValidB(vld_b[g]),
      .Collision(coll[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ramp(input logic [7:0] a);
    logic [7:0] n, p;
    n = ~a;
    p = a + 8'd1;
    return {a, n, p, 8'h5A};
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m   [256];
  bit          mk  [256];
  logic [31:0] ed  [NC][2];
  bit          ev  [NC][2];
  bit          ek  [NC][2];
  logic [31:0] pd  [NC][2];
  bit          pv  [NC][2];
  bit          pk  [NC][2];
  bit          ecoll;
  int          vcnt [NC];
  bit          count_en = 1'b0;

  logic [31:0] pre [2];
  logic [31:0] post [2];
  bit          kpre [2];
  bit          kpost [2];
  bit          p_en [2];
  bit          p_wr [2];
  bit          rv, rk;
  logic [31:0] rd;

  task automatic mwrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int l = 0; l < 4; l++)
      if (be[l]) m[a][8*l +: 8] = d[8*l +: 8];
    if (be == 4'hF) mk[a] = 1'b1;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < 2; p++) begin
          ed[c][p] = '0; ek[c][p] = 1'b1; ev[c][p] = 1'b0;
          pd[c][p] = '0; pk[c][p] = 1'b0; pv[c][p] = 1'b0;
        end
      ecoll = 1'b0;
    end else begin
      p_en[0] = en_a; p_wr[0] = wr_a; p_en[1] = en_b; p_wr[1] = wr_b;
      pre[0] = m[addr_a]; kpre[0] = mk[addr_a];
      pre[1] = m[addr_b]; kpre[1] = mk[addr_b];
      if (en_b && wr_b) mwrite(addr_b, in_b, be_b);
      if (en_a && wr_a) mwrite(addr_a, in_a, be_a);  // A applied last: its lanes win
      post[0] = m[addr_a]; kpost[0] = mk[addr_a];
      post[1] = m[addr_b]; kpost[1] = mk[addr_b];
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < 2; p++) begin
          rv = 1'b0; rk = 1'b0; rd = '0;
          if (p_en[p]) begin
            if (!p_wr[p]) begin
              rv = 1'b1; rd = pre[p]; rk = kpre[p];
            end else if (c % 3 == 0) begin
              rv = 1'b1; rd = pre[p]; rk = kpre[p];
            end else if (c % 3 == 1) begin
              rv = 1'b1; rd = post[p]; rk = kpost[p];
            end
          end
          if (c < 3) begin
            ev[c][p] = pv[c][p];
            if (pv[c][p]) begin ed[c][p] = pd[c][p]; ek[c][p] = pk[c][p]; end
            pv[c][p] = rv; pd[c][p] = rd; pk[c][p] = rk;
          end else begin
            ev[c][p] = rv;
            if (rv) begin ed[c][p] = rd; ek[c][p] = rk; end
          end
        end
      ecoll = en_a && en_b && (addr_a == addr_b) && (wr_a || wr_b);
    end
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("cyc c%0d ValidA", c), 32'(vld_a[c]), 32'(ev[c][0]));
      chk($sformatf("cyc c%0d ValidB", c), 32'(vld_b[c]), 32'(ev[c][1]));
      if (ek[c][0]) chk($sformatf("cyc c%0d OutputA", c), out_a[c], ed[c][0]);
      if (ek[c][1]) chk($sformatf("cyc c%0d OutputB", c), out_b[c], ed[c][1]);
      chk($sformatf("cyc c%0d Collision", c), 32'(coll[c]), 32'(ecoll));
      if (count_en && vld_a[c] && vld_b[c]) vcnt[c]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic ea, input logic wa, input logic [3:0] ba,
                     input logic [7:0] aa, input logic [31:0] ia,
                     input logic eb, input logic wb, input logic [3:0] bb,
                     input logic [7:0] ab, input logic [31:0] ib);
    @(negedge clk);
    en_a = ea; wr_a = wa; be_a = ba; addr_a = aa; in_a = ia;
    en_b = eb; wr_b = wb; be_b = bb; addr_b = ab; in_b = ib;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  task automatic drv_a(input logic w, input logic [3:0] be, input logic [7:0] a, input logic [31:0] d);
    drv(1'b1, w, be, a, d, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
  endtask

  task automatic drv_b(input logic w, input logic [3:0] be, input logic [7:0] a, input logic [31:0] d);
    drv(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, w, be, a, d);
  endtask

  // Called right after a request is driven: checks OUT_REG=0 copies one edge later,
  // OUT_REG=1 copies the edge after that.
  task automatic two_stage(input bit pb, input logic [31:0] d, input string nm);
    @(posedge clk); #1;
    for (int c = 3; c < NC; c++) begin
      chk($sformatf("%s c%0d data", nm, c), pb ? out_b[c] : out_a[c], d);
      chk($sformatf("%s c%0d valid", nm, c), 32'(pb ? vld_b[c] : vld_a[c]), 32'd1);
    end
    idle();
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s c%0d data", nm, c), pb ? out_b[c] : out_a[c], d);
      chk($sformatf("%s c%0d valid", nm, c), 32'(pb ? vld_b[c] : vld_a[c]), 32'd1);
    end
  endtask

  task automatic mode_check(input bit slow);
    for (int c = 0; c < NC; c++) begin
      if ((c < 3) == slow) begin
        case (c % 3)
          0: begin
            chk($sformatf("rwmode c%0d data", c), out_a[c], 32'h12345678);
            chk($sformatf("rwmode c%0d valid", c), 32'(vld_a[c]), 32'd1);
          end
          1: begin
            chk($sformatf("rwmode c%0d data", c), out_a[c], 32'hCAFEBABE);
            chk($sformatf("rwmode c%0d valid", c), 32'(vld_a[c]), 32'd1);
          end
          default: begin
            chk($sformatf("rwmode c%0d data", c), out_a[c], 32'hAA22CC44);
            chk($sformatf("rwmode c%0d valid", c), 32'(vld_a[c]), 32'd0);
          end
        endcase
      end
    end
  endtask

  initial begin
    en_a = 1'b0; wr_a = 1'b0; be_a = 4'h0; addr_a = 8'h00; in_a = 32'h0;
    en_b = 1'b0; wr_b = 1'b0; be_b = 4'h0; addr_b = 8'h00; in_b = 32'h0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("reset c%0d OutputA", c), out_a[c], 32'h0);
      chk($sformatf("reset c%0d OutputB", c), out_b[c], 32'h0);
      chk($sformatf("reset c%0d ValidA", c), 32'(vld_a[c]), 32'd0);
      chk($sformatf("reset c%0d ValidB", c), 32'(vld_b[c]), 32'd0);
      chk($sformatf("reset c%0d Collision", c), 32'(coll[c]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // ramp preload, both ports writing in parallel
    for (int i = 0; i < 128; i++)
      drv(1'b1, 1'b1, 4'hF, 8'(i), ramp(8'(i)), 1'b1, 1'b1, 4'hF, 8'(i + 128), ramp(8'(i + 128)));
    repeat (3) idle();

    // full-throughput streaming reads on both ports
    for (int c = 0; c < NC; c++) vcnt[c] = 0;
    count_en = 1'b1;
    for (int i = 0; i < 256; i++)
      drv(1'b1, 1'b0, 4'h0, 8'(i), 32'h0, 1'b1, 1'b0, 4'h0, 8'(255 - i), 32'h0);
    repeat (3) idle();
    count_en = 1'b0;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("stream c%0d valid beats", c), 32'(vcnt[c]), 32'd256);
      chk($sformatf("stream c%0d last A", c), out_a[c], 32'hFF00005A);
      chk($sformatf("stream c%0d last B", c), out_b[c], 32'h00FF015A);
    end

    // byte-enable merge
    drv_a(1'b1, 4'hF, 8'h10, 32'hAABBCCDD);
    drv_a(1'b1, 4'h5, 8'h10, 32'h11223344);
    drv_b(1'b0, 4'h0, 8'h10, 32'h0);
    two_stage(1'b1, 32'hAA22CC44, "byteen");

    // same-port read-during-write per RW_MODE
    drv_a(1'b1, 4'hF, 8'h05, 32'h12345678);
    drv_a(1'b0, 4'h0, 8'h10, 32'h0);
    drv_a(1'b1, 4'hF, 8'h05, 32'hCAFEBABE);
    @(posedge clk); #1;
    mode_check(1'b0);
    idle();
    @(posedge clk); #1;
    mode_check(1'b1);
    drv_a(1'b0, 4'h0, 8'h05, 32'h0);
    two_stage(1'b0, 32'hCAFEBABE, "rw readback");

    // write/write collision
    drv(1'b1, 1'b1, 4'h3, 8'h20, 32'h11111111, 1'b1, 1'b1, 4'hF, 8'h20, 32'h22222222);
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) chk($sformatf("ww c%0d Collision", c), 32'(coll[c]), 32'd1);
    idle();
    @(posedge clk); #1;
    for (int c = 0; c < NC; c++) chk($sformatf("ww c%0d Collision clear", c), 32'(coll[c]), 32'd0);
    drv_a(1'b0, 4'h0, 8'h20, 32'h0);
    two_stage(1'b0, 32'h22221111, "ww readback");

    // read/write collision
    drv_a(1'b1, 4'hF, 8'h30, 32'h00000000);
    drv(1'b1, 1'b1, 4'hF, 8'h30, 32'hDEADBEEF, 1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
    two_stage(1'b1, 32'h00000000, "rw collide");
    drv_b(1'b0, 4'h0, 8'h30, 32'h0);
    two_stage(1'b1, 32'hDEADBEEF, "rw readback");

    // reset asserted while reads are in flight
    idle();
    drv(1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("midreset c%0d OutputA", c), out_a[c], 32'h0);
      chk($sformatf("midreset c%0d OutputB", c), out_b[c], 32'h0);
      chk($sformatf("midreset c%0d ValidA", c), 32'(vld_a[c]), 32'd0);
      chk($sformatf("midreset c%0d ValidB", c), 32'(vld_b[c]), 32'd0);
    end
    idle();
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("postreset c%0d ValidA", c), 32'(vld_a[c]), 32'd0);
        chk($sformatf("postreset c%0d ValidB", c), 32'(vld_b[c]), 32'd0);
      end
    end
    repeat (2) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_dual_port.md
# ram_dual_port

Synchronous true dual-port RAM, the parametrised successor to the team's single-port RAM. Two independent ports share one clock and one storage array. Each port supports per-byte write enables and a selectable read-during-write mode. Reads go through an optional output pipeline stage with a valid flag, and same-cycle address collisions are resolved deterministically and flagged. It sits between bus-facing masters (CPU/DMA) and anything that needs concurrent read/write access to shared buffers.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 8, address width; depth = 1<<ADDR_WIDTH words
- BYTE_WIDTH, 8, bits per byte-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
- RW_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
- OUT_REG, 1, 0 = data from array register, 1 = one extra output register stage
- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- EnA / EnB  in  1  port access request, one access per cycle
- WriteA / WriteB  in  1  1 = write, 0 = read; ignored when En low
- ByteEnA / ByteEnB  in  NUM_BYTES  per-lane write enable; ignored on reads
- AddrA / AddrB  in  ADDR_WIDTH  word address
- InputA / InputB  in  DATA_WIDTH  write data
- OutputA / OutputB  out  DATA_WIDTH  read data
- ValidA / ValidB  out  1  OutputX holds data for a completed access this cycle
- Collision  out  1  registered: previous cycle had both ports enabled at the same address with at least one write

## Operation
- Storage is never reset; contents after power-up are undefined.
- Write (En=1, Write=1): lanes with ByteEn[i]=1 take Input[i*BYTE_WIDTH +: BYTE_WIDTH]; other lanes keep their value. ByteEn=0 is a legal no-op write.
- Read (En=1, Write=0): returns the stored word.
- Same-port write, per RW_MODE: READ_FIRST drives Output with the pre-write word and asserts Valid. WRITE_FIRST drives the post-write merged word and asserts Valid. NO_CHANGE holds Output and does not assert Valid.
- Cross-port, same cycle, same address:
  - write/write: port A's enabled lanes win; B's lanes are written only where ByteEnA=0.
  - read/write: the reading port gets the pre-write word regardless of RW_MODE.
  - read/read: both ports get the same word; no collision.
- Collision registers the condition in the cycle it occurs, so it is high for exactly one cycle after each colliding access.
- En=0: no array access; Output holds its last value; Valid deasserts per the pipeline below.

## Timing
- Read latency is 1+OUT_REG cycles from the En edge to Output/Valid.
  - OUT_REG=0: Output/Valid are registered at edge N when the request was sampled at N.
  - OUT_REG=1: the second stage registers at N+1.
- Full throughput: a new access every cycle on each port; Valid tracks the request stream delayed by the latency.
- Reset, asynchronous: Output*=0, Valid*=0, Collision=0, all pipeline registers cleared immediately. Deassertion takes effect at the first rising edge with Rst_n=1.
- Reset mid-operation: in-flight reads are discarded with no Valid. A write sampled on the same edge as Rst_n low is not guaranteed to land in the array.
- Address wrap: none; every ADDR_WIDTH value is a valid word.

## Structure
- Package ram_pkg:
  - RW_MODE encodings RAM_READ_FIRST=0, RAM_WRITE_FIRST=1, RAM_NO_CHANGE=2.
  - A function for lane-masked merge of old/new words.
- Sub-module ram_port_pipe, instantiated once per port:
  - Holds the Output/Valid register and the optional OUT_REG stage.
  - Carries async reset.
- The array and collision logic stay in ram_dual_port.
- Elaboration check: DATA_WIDTH % BYTE_WIDTH == 0 and RW_MODE ≤ 2.

## Test plan
- Reset: assert Rst_n=0 mid-read with OUT_REG=1 -> OutputA/B=0 and ValidA/B=0 immediately; no Valid after release.
- Byte-enable write: A writes 0xAABBCCDD to 0x10 with ByteEn=1111, then 0x11223344 with ByteEn=0101; B reads 0x10 -> 0xAA22CC44 after 1+OUT_REG cycles with ValidB=1.
- RW_MODE sweep: preload 0x12345678 at 0x05, then A writes 0xCAFEBABE to 0x05 and reads the same cycle:
  - READ_FIRST -> 0x12345678, Valid=1.
  - WRITE_FIRST -> 0xCAFEBABE, Valid=1.
  - NO_CHANGE -> Output held, Valid=0.
- Write/write collision: A writes 0x11111111 with ByteEn=0011 and B writes 0x22222222 with ByteEn=1111, both to 0x20 -> readback 0x22221111; Collision=1 for exactly one cycle.
- Read/write collision: preload 0x0 at 0x30; B reads 0x30 while A writes 0xDEADBEEF -> OutputB=0x00000000; next read returns 0xDEADBEEF.
- Throughput: both ports stream 256 back-to-back reads of a ramp pattern -> Valid continuous, data matches address, latency 1+OUT_REG for both OUT_REG values.
